// File: rtl/enemy_group.sv
// rtl/enemy_group.sv - group of independently roaming enemies with hit, respawn and pixel output
//
// Purpose: each enemy steps through a maze of 16x16 tiles, picking a new
// direction at every tile boundary, either at random (shared LFSR) or toward
// the bomberman. It can be hit by an explosion, after which it respawns with a
// faster motion timer or dies permanently. Pixel outputs drive an external
// sprite ROM lookup.
//
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous, active-low
//   display_on      video active; pixel outputs are 0 when low
//   x, y            current pixel coordinate
//   x_b, y_b        bomberman top-left coordinate
//   exp_on          explosion covers the current pixel
//   post_exp_active explosion phase still running
//   chase_en        allow bomberman-seeking direction choice
//   enemy_on        pixel lies inside an alive enemy tile
//   enemy_sel       index of the enemy owning the pixel
//   sprite_addr     enemy sprite ROM address for the pixel
//   enemy_hit       per-enemy flag, high while that enemy is hit
//   bm_collide      bomberman box overlaps an active enemy
//   alive_cnt       number of enemies not dead
//   all_dead        no enemy left alive
module enemy_group #(
  parameter int NUM_ENEMIES = 2,
  parameter int TIMER_MAX   = 4000000,
  parameter int TIMER_STEP  = 400000,
  parameter int TIMER_MIN   = 400000,
  parameter int RESPAWN     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   display_on,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic [9:0]             x_b,
  input  logic [9:0]             y_b,
  input  logic                   exp_on,
  input  logic                   post_exp_active,
  input  logic                   chase_en,
  output logic                   enemy_on,
  output logic [1:0]             enemy_sel,
  output logic [11:0]            sprite_addr,
  output logic [NUM_ENEMIES-1:0] enemy_hit,
  output logic                   bm_collide,
  output logic [2:0]             alive_cnt,
  output logic                   all_dead
);

  localparam int TW = (TIMER_MAX < 2) ? 1 : $clog2(TIMER_MAX + 1);
  localparam logic [9:0] X_WALL_L = 10'd48;
  localparam logic [9:0] Y_WALL_U = 10'd31;
  localparam logic [9:0] START_Y  = 10'd191;

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_GET_DIR, S_CHECK_DIR, S_HIT, S_DEAD
  } state_t;

  typedef enum logic [1:0] {
    DIR_U = 2'd0, DIR_D = 2'd1, DIR_L = 2'd2, DIR_R = 2'd3
  } dir_t;

  state_t        state_q   [NUM_ENEMIES];
  state_t        state_d   [NUM_ENEMIES];
  dir_t          dir_q     [NUM_ENEMIES];
  dir_t          dir_d     [NUM_ENEMIES];
  logic [9:0]    xe_q      [NUM_ENEMIES];
  logic [9:0]    xe_d      [NUM_ENEMIES];
  logic [9:0]    ye_q      [NUM_ENEMIES];
  logic [9:0]    ye_d      [NUM_ENEMIES];
  logic [3:0]    mcnt_q    [NUM_ENEMIES];
  logic [3:0]    mcnt_d    [NUM_ENEMIES];
  logic [TW-1:0] timer_q   [NUM_ENEMIES];
  logic [TW-1:0] timer_d   [NUM_ENEMIES];
  logic [TW-1:0] limit_q   [NUM_ENEMIES];
  logic [TW-1:0] limit_d   [NUM_ENEMIES];
  logic          blocked_q [NUM_ENEMIES];
  logic          blocked_d [NUM_ENEMIES];
  logic [7:0]    offset_q  [NUM_ENEMIES];
  logic [7:0]    offset_d  [NUM_ENEMIES];
  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_d;
  logic [2:0]    alive_v;

  function automatic logic [9:0] start_x(input int i);
    return 10'(48 + 16 * (10 + 2 * i));
  endfunction

  function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic in_tile(input logic [9:0] px, input logic [9:0] py,
                                   input logic [9:0] ex, input logic [9:0] ey);
    return (px >= ex) && (py >= ey) && ((px - ex) < 10'd16) && ((py - ey) < 10'd16);
  endfunction

  // Sprite sheet row offset: three walking frames per facing, left reuses the
  // right frames mirrored horizontally at address time.
  function automatic logic [7:0] row_offset(input state_t s, input dir_t d,
                                            input logic [3:0] mc);
    logic [7:0] base;
    logic [7:0] frame;
    base  = 8'd48;
    frame = 8'd0;
    if (d == DIR_U) base = 8'd0;
    else if (d == DIR_D) base = 8'd96;
    if (mc[3:2] == 2'd1) frame = 8'd16;
    else if (mc[3:2] == 2'd3) frame = 8'd32;
    return (s == S_HIT) ? 8'd144 : (base + frame);
  endfunction

  always_comb begin
    logic [5:0] r;
    logic [5:0] tx;
    logic [5:0] ty;
    logic       blk;
    logic [9:0] ax;
    logic [9:0] ay;
    r      = '0;
    tx     = '0;
    ty     = '0;
    blk    = 1'b0;
    ax     = '0;
    ay     = '0;
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      state_d[i]   = state_q[i];
      dir_d[i]     = dir_q[i];
      xe_d[i]      = xe_q[i];
      ye_d[i]      = ye_q[i];
      mcnt_d[i]    = mcnt_q[i];
      timer_d[i]   = timer_q[i];
      limit_d[i]   = limit_q[i];
      blocked_d[i] = blocked_q[i];
      offset_d[i]  = row_offset(state_q[i], dir_q[i], mcnt_q[i]);
      // Each enemy sees the LFSR rotated by its own nibble so their choices decorrelate.
      r = 6'((lfsr_q << (4 * i)) | (lfsr_q >> (16 - 4 * i)));

      case (state_q[i])
        S_IDLE: begin
          if (exp_on && in_tile(x, y, xe_q[i], ye_q[i])) begin
            state_d[i] = S_HIT;
            timer_d[i] = '0;
          end else if (timer_q[i] == limit_q[i]) begin
            timer_d[i] = '0;
            if (mcnt_q[i] == 4'd15) begin
              mcnt_d[i]  = 4'd0;
              state_d[i] = S_GET_DIR;
            end else begin
              mcnt_d[i]  = mcnt_q[i] + 4'd1;
              state_d[i] = S_MOVE;
            end
          end else begin
            timer_d[i] = timer_q[i] + TW'(1);
          end
        end
        S_MOVE: begin
          case (dir_q[i])
            DIR_U:   ye_d[i] = ye_q[i] - 10'd1;
            DIR_D:   ye_d[i] = ye_q[i] + 10'd1;
            DIR_L:   xe_d[i] = xe_q[i] - 10'd1;
            default: xe_d[i] = xe_q[i] + 10'd1;
          endcase
          state_d[i] = S_IDLE;
        end
        S_GET_DIR: begin
          if (chase_en && r[5]) begin
            ax = absdiff(x_b, xe_q[i]);
            ay = absdiff(y_b, ye_q[i]);
            // Equal distances favour the horizontal axis.
            if (ax >= ay) dir_d[i] = (x_b > xe_q[i]) ? DIR_R : DIR_L;
            else          dir_d[i] = (y_b > ye_q[i]) ? DIR_D : DIR_U;
          end else if ((r[4:2] == 3'd0) || blocked_q[i]) begin
            dir_d[i] = dir_t'(r[1:0]);
          end
          state_d[i] = S_CHECK_DIR;
        end
        S_CHECK_DIR: begin
          tx  = 6'((xe_q[i] - X_WALL_L) >> 4);
          ty  = 6'((ye_q[i] - Y_WALL_U) >> 4);
          blk = 1'b0;
          // Edge tests come before the +/-1 so a step off tile 0 cannot wrap.
          case (dir_q[i])
            DIR_U: begin blk = (ty == 6'd0);   ty = ty - 6'd1; end
            DIR_D: begin blk = (ty >= 6'd26);  ty = ty + 6'd1; end
            DIR_L: begin blk = (tx == 6'd0);   tx = tx - 6'd1; end
            default: begin blk = (tx >= 6'd32); tx = tx + 6'd1; end
          endcase
          if (tx[0] && ty[0]) blk = 1'b1;
          blocked_d[i] = blk;
          state_d[i]   = blk ? S_GET_DIR : S_MOVE;
        end
        S_HIT: begin
          if (!post_exp_active) begin
            if (RESPAWN != 0) begin
              state_d[i]   = S_IDLE;
              xe_d[i]      = start_x(i);
              ye_d[i]      = START_Y;
              dir_d[i]     = DIR_U;
              mcnt_d[i]    = 4'd0;
              timer_d[i]   = '0;
              blocked_d[i] = 1'b0;
              if (33'(limit_q[i]) >= 33'(TIMER_MIN) + 33'(TIMER_STEP))
                limit_d[i] = limit_q[i] - TW'(TIMER_STEP);
              else
                limit_d[i] = TW'(TIMER_MIN);
            end else begin
              state_d[i] = S_DEAD;
            end
          end
        end
        default: state_d[i] = S_DEAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        state_q[i]   <= S_IDLE;
        dir_q[i]     <= DIR_U;
        xe_q[i]      <= start_x(i);
        ye_q[i]      <= START_Y;
        mcnt_q[i]    <= 4'd0;
        timer_q[i]   <= '0;
        limit_q[i]   <= TW'(TIMER_MAX);
        blocked_q[i] <= 1'b0;
        offset_q[i]  <= 8'd0;
      end
    end else begin
      lfsr_q    <= lfsr_d;
      state_q   <= state_d;
      dir_q     <= dir_d;
      xe_q      <= xe_d;
      ye_q      <= ye_d;
      mcnt_q    <= mcnt_d;
      timer_q   <= timer_d;
      limit_q   <= limit_d;
      blocked_q <= blocked_d;
      offset_q  <= offset_d;
    end
  end

  always_comb begin
    logic [3:0] col;
    enemy_on    = 1'b0;
    enemy_sel   = 2'd0;
    sprite_addr = 12'd0;
    enemy_hit   = '0;
    bm_collide  = 1'b0;
    alive_v     = 3'd0;
    col         = 4'd0;
    // Walk from the highest index down so the lowest overlapping enemy wins.
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (state_q[i] != S_DEAD) alive_v = alive_v + 3'd1;
      enemy_hit[i] = (state_q[i] == S_HIT);
      if ((state_q[i] inside {S_IDLE, S_MOVE, S_GET_DIR, S_CHECK_DIR}) &&
          (absdiff(x_b, xe_q[i]) < 10'd16) && (absdiff(y_b, ye_q[i]) < 10'd16))
        bm_collide = 1'b1;
      if (display_on && (state_q[i] != S_DEAD) && in_tile(x, y, xe_q[i], ye_q[i])) begin
        enemy_on  = 1'b1;
        enemy_sel = 2'(i);
        col       = 4'(x - xe_q[i]);
        if (dir_q[i] == DIR_L) col = 4'd15 - col;
        sprite_addr = 12'(col) + ((12'(y - ye_q[i]) + 12'(offset_q[i])) << 4);
      end
    end
  end

  assign alive_cnt = alive_v;
  assign all_dead  = (alive_v == 3'd0);

endmodule

// File: tb/tb_enemy_group.sv
// tb/tb_enemy_group.sv - self-checking bench for enemy_group, respawning and permanent-death instances
module tb_enemy_group;

  localparam int IDLE = 0, MOVE = 1, GETD = 2, CHKD = 3, HIT = 4, DEAD = 5;
  localparam int DU = 0, DD = 1, DL = 2, DR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       display_on = 1'b1;
  logic [9:0] x = '0, y = '0, x_b = '0, y_b = '0;
  logic       exp_on = 1'b0, post_exp_active = 1'b0, chase_en = 1'b0;

  logic       on0, on1, bm0, bm1, dead0, dead1;
  logic [1:0] sel0, sel1, hit0, hit1;
  logic [11:0] addr0, addr1;
  logic [2:0] alive0, alive1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enemy_group #(.NUM_ENEMIES(2), .TIMER_MAX(3), .TIMER_STEP(1), .TIMER_MIN(1), .RESPAWN(1)) u_resp (
    .clk(clk), .reset(rst), .display_on(display_on), .x(x), .y(y), .x_b(x_b), .y_b(y_b),
    .exp_on(exp_on), .post_exp_active(post_exp_active), .chase_en(chase_en),
    .enemy_on(on0), .enemy_sel(sel0), .sprite_addr(addr0), .enemy_hit(hit0),
    .bm_collide(bm0), .alive_cnt(alive0), .all_dead(dead0));

  enemy_group #(.NUM_ENEMIES(2), .TIMER_MAX(3), .TIMER_STEP(1), .TIMER_MIN(1), .RESPAWN(0)) u_dead (
    .clk(clk), .reset(rst), .display_on(display_on), .x(x), .y(y), .x_b(x_b), .y_b(y_b),
    .exp_on(exp_on), .post_exp_active(post_exp_active), .chase_en(chase_en),
    .enemy_on(on1), .enemy_sel(sel1), .sprite_addr(addr1), .enemy_hit(hit1),
    .bm_collide(bm1), .alive_cnt(alive1), .all_dead(dead1));

  // Model: index [k][i], k=0 respawning instance, k=1 permanent-death instance.
  int m_st [2][2];
  int m_x  [2][2];
  int m_y  [2][2];
  int m_dir[2][2];
  int m_mc [2][2];
  int m_tm [2][2];
  int m_lim[2][2];
  int m_blk[2][2];
  int m_off[2][2];
  int m_lfsr;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit on_tile(int px, int py, int ex, int ey);
    return (px >= ex) && (px < ex + 16) && (py >= ey) && (py < ey + 16);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 2; i++) begin
        m_st[k][i] = IDLE; m_x[k][i] = 208 + 32 * i; m_y[k][i] = 191; m_dir[k][i] = DU;
        m_mc[k][i] = 0; m_tm[k][i] = 0; m_lim[k][i] = 3; m_blk[k][i] = 0; m_off[k][i] = 0;
      end
  endtask

  task automatic model_step();
    int r, q, base, noff, dx, dy, nx, ny;
    bit blocked;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 2; i++) begin
        r = (((m_lfsr << (4 * i)) | (m_lfsr >> (16 - 4 * i))) & 16'hFFFF) % 64;
        q = (m_mc[k][i] / 4) % 4;
        base = (m_dir[k][i] == DU) ? 0 : (m_dir[k][i] == DD) ? 96 : 48;
        noff = (m_st[k][i] == HIT) ? 144 : base + ((q == 1) ? 16 : (q == 3) ? 32 : 0);
        case (m_st[k][i])
          IDLE: begin
            if (exp_on && on_tile(int'(x), int'(y), m_x[k][i], m_y[k][i])) begin
              m_st[k][i] = HIT; m_tm[k][i] = 0;
            end else if (m_tm[k][i] == m_lim[k][i]) begin
              m_tm[k][i] = 0;
              if (m_mc[k][i] == 15) begin m_mc[k][i] = 0; m_st[k][i] = GETD; end
              else begin m_mc[k][i] += 1; m_st[k][i] = MOVE; end
            end else m_tm[k][i] += 1;
          end
          MOVE: begin
            if (m_dir[k][i] == DU) m_y[k][i] -= 1;
            else if (m_dir[k][i] == DD) m_y[k][i] += 1;
            else if (m_dir[k][i] == DL) m_x[k][i] -= 1;
            else m_x[k][i] += 1;
            m_st[k][i] = IDLE;
          end
          GETD: begin
            if (chase_en && (r / 32) % 2 == 1) begin
              dx = int'(x_b) - m_x[k][i];
              dy = int'(y_b) - m_y[k][i];
              if (iabs(dx) >= iabs(dy)) m_dir[k][i] = (dx > 0) ? DR : DL;
              else m_dir[k][i] = (dy > 0) ? DD : DU;
            end else if ((r / 4) % 8 == 0 || m_blk[k][i] != 0) m_dir[k][i] = r % 4;
            m_st[k][i] = CHKD;
          end
          CHKD: begin
            nx = (m_x[k][i] - 48) / 16 + ((m_dir[k][i] == DR) ? 1 : (m_dir[k][i] == DL) ? -1 : 0);
            ny = (m_y[k][i] - 31) / 16 + ((m_dir[k][i] == DD) ? 1 : (m_dir[k][i] == DU) ? -1 : 0);
            blocked = (nx < 0) || (nx > 32) || (ny < 0) || (ny > 26) || ((nx % 2 == 1) && (ny % 2 == 1));
            m_blk[k][i] = blocked;
            m_st[k][i] = blocked ? GETD : MOVE;
          end
          HIT: begin
            if (!post_exp_active) begin
              if (k == 0) begin
                m_st[k][i] = IDLE; m_x[k][i] = 208 + 32 * i; m_y[k][i] = 191; m_dir[k][i] = DU;
                m_mc[k][i] = 0; m_tm[k][i] = 0; m_blk[k][i] = 0;
                m_lim[k][i] = (m_lim[k][i] - 1 < 1) ? 1 : m_lim[k][i] - 1;
              end else m_st[k][i] = DEAD;
            end
          end
          default: ;
        endcase
        m_off[k][i] = noff;
      end
    m_lfsr = ((m_lfsr << 1) & 16'hFFFF) | ($countones(m_lfsr & 16'hB400) % 2);
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      int eon = 0, esel = 0, eaddr = 0, ebm = 0, ealive = 0, ehit = 0, col = 0;
      for (int i = 0; i < 2; i++) begin
        if (m_st[k][i] != DEAD) ealive++;
        if (m_st[k][i] == HIT) ehit |= (1 << i);
        if (m_st[k][i] <= CHKD && iabs(int'(x_b) - m_x[k][i]) < 16 && iabs(int'(y_b) - m_y[k][i]) < 16)
          ebm = 1;
        if (display_on && eon == 0 && m_st[k][i] != DEAD && on_tile(int'(x), int'(y), m_x[k][i], m_y[k][i])) begin
          eon = 1; esel = i;
          col = int'(x) - m_x[k][i];
          if (m_dir[k][i] == DL) col = 15 - col;
          eaddr = (col + (int'(y) - m_y[k][i] + m_off[k][i]) * 16) % 4096;
        end
      end
      if (k == 0) begin
        chk("resp.enemy_on", 32'(on0), eon);   chk("resp.enemy_sel", 32'(sel0), esel);
        chk("resp.sprite_addr", 32'(addr0), eaddr); chk("resp.enemy_hit", 32'(hit0), ehit);
        chk("resp.bm_collide", 32'(bm0), ebm); chk("resp.alive_cnt", 32'(alive0), ealive);
        chk("resp.all_dead", 32'(dead0), (ealive == 0));
      end else begin
        chk("dead.enemy_on", 32'(on1), eon);   chk("dead.enemy_sel", 32'(sel1), esel);
        chk("dead.sprite_addr", 32'(addr1), eaddr); chk("dead.enemy_hit", 32'(hit1), ehit);
        chk("dead.bm_collide", 32'(bm1), ebm); chk("dead.alive_cnt", 32'(alive1), ealive);
        chk("dead.all_dead", 32'(dead1), (ealive == 0));
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic edge_();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; exp_on = 1'b0; post_exp_active = 1'b0; chase_en = 1'b0;
    edge_(); edge_();
    rst = 1'b1;
  endtask

  initial begin
    int post_left = 0;
    int e, phase;

    // Reset state and pixel/collision geometry.
    rst = 1'b0; display_on = 1'b1;
    edge_(); edge_();
    x = 10'd213; y = 10'd194; x_b = 10'd223; y_b = 10'd191;
    settle();
    chk("lit.alive_reset", 32'(alive0), 2); chk("lit.all_dead_reset", 32'(dead0), 0);
    chk("lit.hit_reset", 32'(hit0), 0);     chk("lit.on_e0", 32'(on0), 1);
    chk("lit.sel_e0", 32'(sel0), 0);        chk("lit.addr_e0", 32'(addr0), 53);
    chk("lit.bm_plus15", 32'(bm0), 1);
    x_b = 10'd224; x = 10'd241; y = 10'd191;
    settle();
    chk("lit.bm_plus16", 32'(bm0), 0); chk("lit.sel_e1", 32'(sel0), 1); chk("lit.addr_e1", 32'(addr0), 1);
    display_on = 1'b0;
    settle();
    chk("lit.on_blank", 32'(on0), 0); chk("lit.addr_blank", 32'(addr0), 0);
    display_on = 1'b1;

    // First step after four idle cycles plus the move.
    rst = 1'b1; x = 10'd208; y = 10'd190;
    repeat (4) edge_();
    settle(); chk("lit.step_not_yet", 32'(on0), 0);
    edge_();
    settle(); chk("lit.step_done", 32'(on0), 1);

    // Hit enemy 1 and hold the explosion phase for ten cycles.
    do_reset();
    exp_on = 1'b1; post_exp_active = 1'b1; x = 10'd241; y = 10'd191;
    edge_();
    exp_on = 1'b0;
    for (int j = 0; j < 10; j++) begin
      settle();
      chk("lit.hit_held", 32'(hit0), 2);
      if (j == 1) chk("lit.hit_sprite", 32'(addr0), 2305);
      edge_();
    end
    post_exp_active = 1'b0;
    edge_();
    x = 10'd240; y = 10'd190;
    settle(); chk("lit.dead_alive1", 32'(alive1), 1);
    repeat (3) edge_();
    settle(); chk("lit.respawn_wait", 32'(on0), 0);
    edge_();
    settle(); chk("lit.respawn_step", 32'(on0), 1); chk("lit.respawn_sel", 32'(sel0), 1);

    // Permanent death of both enemies.
    do_reset();
    exp_on = 1'b1; post_exp_active = 1'b0; x = 10'd208; y = 10'd191;
    edge_();
    settle(); chk("lit.kill_hit0", 32'(hit1), 1);
    x = 10'd240;
    edge_();
    settle(); chk("lit.kill_alive1", 32'(alive1), 1);
    exp_on = 1'b0;
    edge_();
    x = 10'd208; x_b = 10'd208; y_b = 10'd191;
    settle();
    chk("lit.kill_alive0", 32'(alive1), 0); chk("lit.kill_all_dead", 32'(dead1), 1);
    chk("lit.kill_no_pixel", 32'(on1), 0);  chk("lit.kill_no_bm", 32'(bm1), 0);

    // Randomised run with wall-seeking chase phases and occasional resets.
    do_reset();
    for (int c = 0; c < 30000; c++) begin
      phase = c / 5000;
      rst = ($urandom_range(0, 7999) != 0);
      display_on = ($urandom_range(0, 9) != 0);
      e = int'($urandom_range(0, 1));
      x = 10'(m_x[0][e] + int'($urandom_range(0, 23)) - 4);
      y = 10'(m_y[0][e] + int'($urandom_range(0, 23)) - 4);
      if (phase == 1 || phase == 4) begin
        chase_en = 1'b1; x_b = 10'd1023; y_b = 10'(m_y[0][0]);
        exp_on = 1'b0;
      end else if (phase == 3) begin
        chase_en = 1'b1; x_b = 10'(m_x[0][0]); y_b = 10'd1000;
        exp_on = 1'b0;
      end else begin
        chase_en = $urandom_range(0, 1) != 0;
        e = int'($urandom_range(0, 1));
        x_b = 10'(m_x[0][e] + int'($urandom_range(0, 39)) - 20);
        y_b = 10'(m_y[0][e] + int'($urandom_range(0, 39)) - 20);
        exp_on = ($urandom_range(0, 63) == 0);
        if (exp_on) post_left = int'($urandom_range(0, 15));
      end
      post_exp_active = (post_left > 0);
      if (post_left > 0) post_left--;
      settle();
      edge_();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
